memory_arbiter: RTL and testbench

- Two-client arbiter directly upstream of the memory mux stage.
- Owns the mux select and gates each client's execute strobe, so only the granted client's request reaches the memory unit.
- Holds the grant for one full memory transaction (execute to finished) and routes the finished pulse back to the owning client.
- A watchdog releases a grant that never completes and raises a sticky error.

---
 rtl/memory_arbiter_pkg.sv | 35 +++
 rtl/memory_arbiter_watchdog.sv | 32 +++
 rtl/memory_arbiter.sv | 97 +++++++++
 tb/tb_memory_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for memory_arbiter: FSM state encodings, client IDs (same
// polarity as the memory mux select) and the arbitration helper.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_t;

  // A tie goes to A unless rotation is enabled and A owned memory last.
  function automatic client_t pick_client(
    input logic    req_a,
    input logic    req_b,
    input client_t last_owner,
    input logic    rr_en
  );
    client_t winner;
    winner = CLIENT_A;
    if (req_a && req_b) begin
      if (rr_en && (last_owner == CLIENT_A)) begin
        winner = CLIENT_B;
      end
    end else if (req_b) begin
      winner = CLIENT_B;
    end
    return winner;
  endfunction

endpackage

// File: rtl/memory_arbiter_watchdog.sv
// Grant watchdog (arb_watchdog) for memory_arbiter: counts GRANT cycles and
// flags the terminal count; TIMEOUT_CYCLES = 0 disables the flag.
module memory_arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = enable && (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/memory_arbiter.sv
// Two-client arbiter in front of the memory mux. Build option
// MEMORY_ARBITER_ROUND_ROBIN_EN rotates ties; otherwise client A wins ties.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       execute_a,
  input  logic       execute_b,
  input  logic       mem_finished,
  output logic       sel,
  output logic       exec_a_out,
  output logic       exec_b_out,
  output logic       grant_a,
  output logic       grant_b,
  output logic       finished_a,
  output logic       finished_b,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] dbg_state
);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_t state;
  client_t    last_owner;
  client_t    winner;
  logic       wd_expired;

  always_comb begin
    winner = pick_client(execute_a, execute_b, last_owner, RR_EN);
  end

  memory_arbiter_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != GRANT),
    .enable  (state == GRANT),
    .expired (wd_expired)
  );

  // Handshake: a client holds execute_x high until it sees finished_x; the
  // memory unit answers the gated execute with a single-cycle mem_finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= CLIENT_A;
      grant_a     <= 1'b0;
      grant_b     <= 1'b0;
      timeout_err <= 1'b0;
      last_owner  <= CLIENT_B;
    end else begin
      case (state)
        IDLE: begin
          if (execute_a || execute_b) begin
            state   <= GRANT;
            sel     <= winner;
            grant_a <= (winner == CLIENT_A);
            grant_b <= (winner == CLIENT_B);
          end
        end
        GRANT: begin
          // A completion landing on the terminal count still counts as success.
          if (mem_finished || wd_expired) begin
            state      <= RELEASE;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            last_owner <= sel ? CLIENT_B : CLIENT_A;
            if (!mem_finished) begin
              timeout_err <= 1'b1;
            end
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign exec_a_out = grant_a & execute_a;
  assign exec_b_out = grant_b & execute_b;
  assign finished_a = grant_a & mem_finished;
  assign finished_b = grant_b & mem_finished;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: epoch planner with a cycle-indexed ownership map
// and an event scoreboard for grants, finished pulses and timeouts.
module tb_memory_arbiter;

  localparam int TMO      = 8;
  localparam int EV_GRANT = 1;
  localparam int EV_FIN   = 2;
  localparam int EV_TMO   = 3;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       execute_a;
  logic       execute_b;
  logic       mem_finished;
  logic       sel;
  logic       exec_a_out;
  logic       exec_b_out;
  logic       grant_a;
  logic       grant_b;
  logic       finished_a;
  logic       finished_b;
  logic       busy;
  logic       timeout_err;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  memory_arbiter #(
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .execute_a    (execute_a),
    .execute_b    (execute_b),
    .mem_finished (mem_finished),
    .sel          (sel),
    .exec_a_out   (exec_a_out),
    .exec_b_out   (exec_b_out),
    .grant_a      (grant_a),
    .grant_b      (grant_b),
    .finished_a   (finished_a),
    .finished_b   (finished_b),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  int          cyc;
  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];
  int          own_map[int];   // 1 = A owns, 2 = B owns, 3 = release cycle
  bit          ea_p[int];
  bit          eb_p[int];
  bit          mf_p[int];
  int          err_at  = -1;
  int          err_end = 1 << 30;
  int          m_last  = 1;    // 0 = A, 1 = B
  bit          m_err;
  bit          mon_en;
  logic        prev_ga, prev_gb, prev_err;
  int          mon_v;

  // ---------------- clock/reset and driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] ev(input int kind, input int cli, input int c);
    return {kind[3:0], cli[3:0], c[23:0]};
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      execute_a    = 1'b0;
      execute_b    = 1'b0;
      mem_finished = 1'($urandom_range(0, 1));
      step();
    end
    mem_finished = 1'b0;
  endtask

  // Plan one burst of requests from the current (idle) cycle, push the
  // expected events, then drive it. oa/ob: request offset (-1 = none),
  // ra/rb: number of services, flat: latency of the first service
  // (-1 random, 8 = never finishes).
  task automatic epoch(input int oa, input int ob, input int ra, input int rb,
                       input int flat, input bit allow_tmo);
    int s, c, g, f, rel, lat, w, drop, e;
    int st[2];
    int pend[2];
    bit first;
    bit a_ok, b_ok;
    s       = cyc;
    st[0]   = s + oa;
    st[1]   = s + ob;
    pend[0] = (oa >= 0) ? ra : 0;
    pend[1] = (ob >= 0) ? rb : 0;
    c       = s;
    first   = 1'b1;
    while (pend[0] > 0 || pend[1] > 0) begin
      e = 1 << 30;
      if (pend[0] > 0 && st[0] < e) e = st[0];
      if (pend[1] > 0 && st[1] < e) e = st[1];
      if (e > c) c = e;
      a_ok = (pend[0] > 0) && (st[0] <= c);
      b_ok = (pend[1] > 0) && (st[1] <= c);
      if (a_ok && b_ok) w = RR ? ((m_last == 0) ? 1 : 0) : 0;
      else              w = a_ok ? 0 : 1;
      g = c + 1;
      if (first && flat >= 0) lat = flat;
      else                    lat = $urandom_range(0, allow_tmo ? 8 : 7);
      first = 1'b0;
      exp_q.push_back(ev(EV_GRANT, w, g));
      if (lat < TMO) begin
        f = g + lat;
        mf_p[f] = 1'b1;
        exp_q.push_back(ev(EV_FIN, w, f));
        rel = f + 1;
      end else begin
        rel = g + TMO;
        if (!m_err) begin
          exp_q.push_back(ev(EV_TMO, w, rel));
          err_at = rel;
          m_err  = 1'b1;
        end
      end
      for (int k = g; k < rel; k++) own_map[k] = w + 1;
      own_map[rel] = 3;
      drop = rel;
      if (lat >= 2 && $urandom_range(0, 3) == 0) drop = g + 1;
      for (int k = st[w]; k < drop; k++) begin
        if (w == 0) ea_p[k] = 1'b1;
        else        eb_p[k] = 1'b1;
      end
      pend[w]--;
      st[w] = rel;
      if ($urandom_range(0, 3) == 0) mf_p[rel] = 1'b1;
      m_last = w;
      c = rel + 1;
    end
    for (int cc = s; cc <= c; cc++) begin
      execute_a    = ea_p.exists(cc);
      execute_b    = eb_p.exists(cc);
      mem_finished = mf_p.exists(cc);
      step();
    end
    execute_a    = 1'b0;
    execute_b    = 1'b0;
    mem_finished = 1'b0;
  endtask

  // B is granted, reset lands in its third GRANT cycle, then a stray finish.
  task automatic reset_mid();
    int s, g;
    s = cyc;
    g = s + 1;
    exp_q.push_back(ev(EV_GRANT, 1, g));
    for (int k = g; k <= g + 2; k++) own_map[k] = 2;
    err_end = g + 3;
    m_last  = 1;
    for (int cc = s; cc <= g + 5; cc++) begin
      execute_a    = 1'b0;
      execute_b    = (cc <= g + 2);
      rst          = (cc == g + 2);
      mem_finished = (cc == g + 4);
      step();
      if (cc == g + 2) begin
        #3;
        chk("sel_after_rst", sel, 1'b0);
        chk("state_after_rst", dbg_state == 2'd0, 1'b1);
      end
    end
    rst          = 1'b0;
    execute_b    = 1'b0;
    mem_finished = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic sb_check(input logic [31:0] got);
    logic [31:0] want;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind=%0d cli=%0d cycle=%0d, expected no event",
               got[31:28], got[27:24], got[23:0]);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cli=%0d cycle=%0d, expected kind=%0d cli=%0d cycle=%0d",
                 got[31:28], got[27:24], got[23:0], want[31:28], want[27:24], want[23:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_v = own_map.exists(cyc) ? own_map[cyc] : 0;
      chk("grant_a", grant_a, mon_v == 1);
      chk("grant_b", grant_b, mon_v == 2);
      chk("busy", busy, mon_v != 0);
      chk("exec_a_out", exec_a_out, (mon_v == 1) && execute_a);
      chk("exec_b_out", exec_b_out, (mon_v == 2) && execute_b);
      if (mon_v == 1 || mon_v == 2) chk("sel", sel, mon_v == 2);
      chk("timeout_err", timeout_err, err_at >= 0 && cyc >= err_at && cyc < err_end);
      if (grant_a && !prev_ga) sb_check(ev(EV_GRANT, 0, cyc));
      if (grant_b && !prev_gb) sb_check(ev(EV_GRANT, 1, cyc));
      if (finished_a || finished_b)
        sb_check(ev(EV_FIN, finished_b ? (finished_a ? 3 : 1) : 0, cyc));
      if (timeout_err && !prev_err) sb_check(ev(EV_TMO, prev_gb ? 1 : 0, cyc));
    end
    prev_ga  = grant_a;
    prev_gb  = grant_b;
    prev_err = timeout_err;
  end

  // ---------------- stimulus ----------------
  initial begin
    int oa, ob;
    rst          = 1'b1;
    execute_a    = 1'b0;
    execute_b    = 1'b0;
    mem_finished = 1'b0;
    cyc          = 0;
    n_tests      = 0;
    n_fail       = 0;
    m_err        = 1'b0;
    mon_en       = 1'b0;
    repeat (3) step();
    rst    = 1'b0;
    mon_en = 1'b1;
    #3;
    chk("sel_reset", sel, 1'b0);
    chk("state_reset", dbg_state == 2'd0, 1'b1);

    epoch(0, -1, 1, 0, 4, 1'b0);    // single A, finish 4 cycles into grant
    gap(2);
    epoch(0, 0, 2, 1, 3, 1'b0);     // tie with A asking twice
    gap(1);
    epoch(3, 0, 1, 1, 5, 1'b0);     // B owns, A arrives mid-transaction
    epoch(0, 2, 1, 1, 8, 1'b0);     // A times out, then B is served
    epoch(0, -1, 1, 0, 7, 1'b0);    // finish on the terminal-count cycle
    gap(2);
    for (int i = 0; i < 24; i++) begin
      oa = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 4));
      ob = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 4));
      if (oa < 0 && ob < 0) oa = 0;
      epoch(oa, ob, $urandom_range(1, 3), $urandom_range(1, 3), -1,
            $urandom_range(0, 3) == 0);
      gap($urandom_range(0, 2));
    end
    reset_mid();
    epoch(0, 0, 1, 1, -1, 1'b0);    // first tie after reset
    epoch(0, 0, 2, 2, -1, 1'b0);
    gap(4);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of run by cycle %0d, expected finish", cyc);
    $fatal(1, "bench time limit reached");
  end

endmodule
